// File: rtl/forward_arbiter_wrr.sv
// forward_arbiter_wrr: per-slave forward arbiter with burst locking, weighted round-robin
// and full-aware push qualification.
module forward_arbiter_wrr #(
  parameter int masters = 4,
  parameter int slaves = 2,
  parameter int i_am_slave_number = 0,
  parameter int WEIGHT_W = 3,
  localparam int DW = slaves > 1 ? $clog2(slaves) : 1,
  localparam int MW = $clog2(masters)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                master_fifo_empty [0:masters-1],
  input  logic [DW-1:0]       master_slave_dest [0:masters-1],
  input  logic                master_fifo_last  [0:masters-1],
  input  logic [WEIGHT_W-1:0] master_weight     [0:masters-1],
  input  logic                slave_fifo_full,
  output logic                push_to_fifo,
  output logic [masters-1:0]  pop_master,
  output logic [MW-1:0]       grant_master_number,
  output logic                burst_locked
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [WEIGHT_W:0] one = 1;
  state_t state, state_n;
  logic [MW-1:0] lock_master, lock_n, rr_ptr, rr_n, idle_grant, grant;
  logic [WEIGHT_W-1:0] credit, credit_n, w;
  logic [WEIGHT_W:0] credit_inc;
  logic [masters-1:0] req;
  logic locked_n, done;

  function automatic logic [MW-1:0] wrap(input int v);
    return MW'(v >= masters ? v - masters : v);
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < masters; i++)
      req[i] = ~master_fifo_empty[i] & (master_slave_dest[i] == DW'(i_am_slave_number));
  end

  // Scanning downward lets the closest requester after rr_ptr win.
  always_comb begin
    idle_grant = rr_ptr;
    for (int k = masters - 1; k >= 0; k--)
      if (req[wrap(int'(rr_ptr) + k)]) idle_grant = wrap(int'(rr_ptr) + k);
  end

  assign grant = state == LOCKED ? lock_master : idle_grant;
  assign push_to_fifo = ARESETn & req[grant] & ~slave_fifo_full;
  assign grant_master_number = grant;
  assign w = master_weight[grant] == '0 ? WEIGHT_W'(1) : master_weight[grant];
  assign credit_inc = {1'b0, credit} + one;
  assign done = push_to_fifo & master_fifo_last[grant];

  always_comb begin
    pop_master = '0;
    for (int i = 0; i < masters; i++)
      pop_master[i] = push_to_fifo & (grant == MW'(i));
  end

  always_comb begin
    state_n = state;
    lock_n = lock_master;
    rr_n = rr_ptr;
    credit_n = credit;
    locked_n = burst_locked;
    if (push_to_fifo && state == IDLE && !master_fifo_last[grant]) begin
      state_n = LOCKED;
      lock_n = grant;
      locked_n = 1'b1;
    end
    if (done) begin
      state_n = IDLE;
      locked_n = 1'b0;
      if (grant == rr_ptr && credit_inc < {1'b0, w}) credit_n = credit_inc[WEIGHT_W-1:0];
      else begin
        rr_n = wrap(int'(grant) + 1);
        credit_n = '0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
      lock_master <= '0;
      rr_ptr <= '0;
      credit <= '0;
      burst_locked <= 1'b0;
    end else begin
      state <= state_n;
      lock_master <= lock_n;
      rr_ptr <= rr_n;
      credit <= credit_n;
      burst_locked <= locked_n;
    end
  end
endmodule

// File: tb/tb_forward_arbiter_wrr.sv
// tb_forward_arbiter_wrr: directed bench with a grant scoreboard for forward_arbiter_wrr.
module tb_forward_arbiter_wrr;
  logic ACLK = 1'b0;
  logic ARESETn;
  logic master_fifo_empty [0:3];
  logic [0:0] master_slave_dest [0:3];
  logic master_fifo_last [0:3];
  logic [2:0] master_weight [0:3];
  logic slave_fifo_full;
  logic push_to_fifo;
  logic [3:0] pop_master;
  logic [1:0] grant_master_number;
  logic burst_locked;
  int n_assert = 0;
  int n_fail = 0;
  int q[$];

  forward_arbiter_wrr #(.masters(4), .slaves(2), .i_am_slave_number(1), .WEIGHT_W(3)) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .master_fifo_empty(master_fifo_empty),
    .master_slave_dest(master_slave_dest),
    .master_fifo_last(master_fifo_last),
    .master_weight(master_weight),
    .slave_fifo_full(slave_fifo_full),
    .push_to_fifo(push_to_fifo),
    .pop_master(pop_master),
    .grant_master_number(grant_master_number),
    .burst_locked(burst_locked)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] r, input logic [3:0] l);
    for (int i = 0; i < 4; i++) begin
      master_fifo_empty[i] = ~r[i];
      master_fifo_last[i] = l[i];
    end
  endtask

  // One cycle: expected transfer goes on the scoreboard, outputs are checked at the negedge.
  task automatic step(input logic ep, input int eg);
    int exp_g;
    if (ep) q.push_back(eg);
    @(negedge ACLK);
    check("push", push_to_fifo, ep);
    if (eg >= 0) check("grant", grant_master_number, eg);
    if (push_to_fifo) begin
      exp_g = q.size() > 0 ? q.pop_front() : -1;
      check("sb_grant", grant_master_number, exp_g);
      check("sb_pop", pop_master, 32'd1 << exp_g);
    end else check("pop_idle", pop_master, 0);
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_lock(input logic v);
    check("burst_locked", burst_locked, v);
  endtask

  initial begin
    ARESETn = 1'b0;
    slave_fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      master_slave_dest[i] = 1'b1;
      master_weight[i] = 3'd1;
    end
    set_req(4'hF, 4'hF);
    step(0, -1);
    step(0, -1);
    chk_lock(0);
    ARESETn = 1'b1;
    step(1, 0);
    step(1, 1);
    step(1, 2);
    step(1, 3);
    step(1, 0);
    set_req(4'b1101, 4'b1001);
    step(1, 2);
    chk_lock(1);
    step(1, 2);
    chk_lock(1);
    step(1, 2);
    set_req(4'b1101, 4'b1101);
    step(1, 2);
    chk_lock(0);
    step(1, 3);
    set_req(4'b0001, 4'hF);
    step(1, 0);
    master_weight[1] = 3'd3;
    set_req(4'b0110, 4'hF);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    step(1, 2);
    set_req(4'hF, 4'hF);
    step(1, 3);
    step(1, 0);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    step(1, 2);
    master_weight[1] = 3'd1;
    set_req(4'b0001, 4'b0000);
    step(1, 0);
    chk_lock(1);
    slave_fifo_full = 1'b1;
    set_req(4'b0101, 4'b0000);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    chk_lock(1);
    slave_fifo_full = 1'b0;
    set_req(4'b0101, 4'b0101);
    step(1, 0);
    chk_lock(0);
    master_slave_dest[3] = 1'b0;
    set_req(4'b1000, 4'hF);
    step(0, 1);
    set_req(4'b1010, 4'b1000);
    step(1, 1);
    chk_lock(1);
    step(1, 1);
    chk_lock(1);
    ARESETn = 1'b0;
    step(0, -1);
    chk_lock(0);
    ARESETn = 1'b1;
    set_req(4'b1000, 4'hF);
    step(0, 0);
    set_req(4'b1011, 4'hF);
    step(1, 0);
    check("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
